// File: rtl/addsub_op_sequencer_if.sv
// Operand/result bundle between a host, the add/sub stage and the sequencer.
// The master side owns operand entry plus the adder's sum/carry.
interface addsub_op_sequencer_if;
    logic [3:0] din;
    logic       load_a;
    logic       load_b;
    logic       op_sub;
    logic       start;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       cin_out;
    logic [3:0] s_in;
    logic       cout_in;
    logic [3:0] result;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic       busy;
    logic       done;

    modport master (
        output din, load_a, load_b, op_sub, start, s_in, cout_in,
        input  a_out, b_out, cin_out, result, flag_c, flag_z, flag_n, flag_v, busy, done
    );

    modport slave (
        input  din, load_a, load_b, op_sub, start, s_in, cout_in,
        output a_out, b_out, cin_out, result, flag_c, flag_z, flag_n, flag_v, busy, done
    );
endinterface

// File: rtl/addsub_op_sequencer.sv
// Operand/result sequencer for a 4-bit add/sub stage; ADDSUB_ACC_EN writes the sum back into A.
// Done pulses SETTLE_CYCLES+1 cycles after start; no backpressure, strobes are ignored outside IDLE.
module addsub_op_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit EDGE_DET      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       cin_q;
    logic [3:0] cnt;
    logic [3:0] result_q;
    logic       flag_c_q;
    logic       flag_z_q;
    logic       flag_n_q;
    logic       flag_v_q;
    logic       busy_q;
    logic       done_q;
    logic       load_a_q;
    logic       load_b_q;
    logic       start_q;

    logic ev_a;
    logic ev_b;
    logic ev_start;
    logic v_nxt;

    assign ev_a     = EDGE_DET ? (bus.load_a & ~load_a_q) : bus.load_a;
    assign ev_b     = EDGE_DET ? (bus.load_b & ~load_b_q) : bus.load_b;
    assign ev_start = EDGE_DET ? (bus.start  & ~start_q)  : bus.start;

    // Subtract flips B's sign, so overflow needs operands of differing sign.
    assign v_nxt = (cin_q ? (a_q[3] != b_q[3]) : (a_q[3] == b_q[3])) & (bus.s_in[3] != a_q[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            cin_q    <= 1'b0;
            cnt      <= 4'd0;
            result_q <= 4'd0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            load_a_q <= bus.load_a;
            load_b_q <= bus.load_b;
            start_q  <= bus.start;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_a) a_q <= bus.din;
                    if (ev_b) b_q <= bus.din;
                    if (ev_start) begin
                        cin_q  <= bus.op_sub;
                        cnt    <= CNT_INIT;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        result_q <= bus.s_in;
                        flag_c_q <= bus.cout_in;
                        flag_z_q <= (bus.s_in == 4'd0);
                        flag_n_q <= bus.s_in[3];
                        flag_v_q <= v_nxt;
`ifdef ADDSUB_ACC_EN
                        a_q      <= bus.s_in;
`endif
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.cin_out = cin_q;
    assign bus.result  = result_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_n  = flag_n_q;
    assign bus.flag_v  = flag_v_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: doc/addsub_op_sequencer.md
# addsub_op_sequencer

Sequential operand/result controller wrapped around the team's combinational 4-bit ripple-carry adder/subtractor stage. Captures A and B from a shared 4-bit entry bus on load strobes, drives the adder's operand and carry-in/subtract-select inputs from registers, waits a configurable settle time, then registers the 4-bit result, carry and status flags with a one-cycle done pulse.

## Interface
- SETTLE_CYCLES, 2, cycles the adder inputs are held stable before result capture; legal 1..15
- EDGE_DET, 1, 1: load_a/load_b/start act on rising edge only; 0: act on every cycle they are high
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- din  in  4  operand entry bus
- load_a  in  1  capture din into A register
- load_b  in  1  capture din into B register
- op_sub  in  1  0 = add, 1 = subtract; sampled on the accepted start
- start  in  1  begin one operation
- a_out  out  4  registered A, to adder operand A
- b_out  out  4  registered B, to adder operand B
- cin_out  out  1  registered op, to adder carry-in/subtract select
- s_in  in  4  adder sum
- cout_in  in  1  adder carry-out
- result  out  4  captured sum
- flag_c, flag_z, flag_n, flag_v  out  1 each  carry, zero, negative, signed overflow
- busy  out  1  high in EXEC
- done  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, EXEC, DONE. Reset -> IDLE.
- Edge detect (EDGE_DET=1): one flop per strobe; event = strobe & ~strobe_q; flops reset to 0.
- IDLE: load_a event -> A <= din; load_b event -> B <= din; both in one cycle -> both get din. start event -> cin_q <= op_sub, cnt <= SETTLE_CYCLES-1, go EXEC.
- Load and start in the same IDLE cycle: load applies at the same edge; the operation uses the new value.
- EXEC: A, B, cin_q frozen; loads and start ignored. cnt==0 -> capture and go DONE, else cnt <= cnt-1.
- Capture: result <= s_in; flag_c <= cout_in; flag_z <= (s_in==0); flag_n <= s_in[3]; flag_v <= add: (a3==b3)&(s3!=a3); sub: (a3!=b3)&(s3!=a3).
- Subtract: flag_c=1 means no borrow (A >= B unsigned).
- DONE: done=1 one cycle, then IDLE unconditionally; loads and start ignored.
- result and flags hold until the next capture.

## Timing
- Reset (async, immediate): state IDLE, A=B=0, cin_q=0, cnt=0, result=0, all flags 0, busy=0, done=0, edge flops 0.
- a_out/b_out/cin_out are register outputs; they change only on clock edges.
- start event in cycle 0 -> busy high cycles 1..SETTLE_CYCLES -> capture at end of cycle SETTLE_CYCLES -> done high cycle SETTLE_CYCLES+1 -> IDLE in SETTLE_CYCLES+2.
- Earliest next accepted start: cycle SETTLE_CYCLES+2.
- start held high (EDGE_DET=1): exactly one operation; a new rising edge is required.
- EDGE_DET=0: start high in IDLE starts immediately, so a held start chains back-to-back operations.
- rst_n low mid-EXEC or DONE: operation aborted, no done pulse, previous result lost.

## Configuration
- ADDSUB_ACC_EN defined: at the capture edge A <= s_in as well (accumulator mode), so a repeated start computes result ± B. A load_a in a later IDLE cycle still overrides A.
- ADDSUB_ACC_EN undefined: A changes only on load_a and reset.

## Test plan
Bench connects the 4-bit add/sub stage or the model s = A + (B ^ {4{cin}}) + cin; SETTLE_CYCLES=2.
- Reset, A=5, B=3, op_sub=0, start -> done in cycle 3; result=8, c=0, z=0, n=1, v=1; cin_out=0.
- A=5, B=3, op_sub=1 -> cin_out=1, result=2, c=1, z=0, n=0, v=0.
- A=3, B=3, sub -> result=0, z=1, c=1. A=3, B=5, sub -> result=14, c=0, n=1, v=0.
- start held high 10 cycles; load_a with din=9 during EXEC -> one done pulse only, A unchanged, busy exactly 2 cycles.
- rst_n pulsed low in the first EXEC cycle -> all outputs 0 at once, no done pulse, next start works normally.
- ADDSUB_ACC_EN: A=1, B=1, add, start twice -> results 2 then 3. Without the macro -> 2 then 2.
